simplez_mem_arbiter: RTL

- Shares the single-port 512x12 main memory between two requesters:
  - Port A: the Simplez CPU datapath.
  - Port B: the program loader / debug port.
- Performs one memory access (read or write) per granted cycle.
- Round-robin arbitration with a bounded burst length, so that neither side starves the other.
- Sits between the requesters and the memory instance; the memory's address, write and data pins are driven only by this block.

---
 rtl/simplez_pkg.sv | 23 ++
 rtl/simplez_rr_pick.sv | 31 +++
 rtl/simplez_mem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/simplez_pkg.sv
// Shared constants and encodings for the Simplez memory arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simplez_pkg;

  localparam int DATAW_DEF = 12;
  localparam int ADDRW_DEF = 9;

  // Value driven on the owner pin for the port granted this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  // Encoding of the "last served" register
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Memory-mapped LED peripheral word
  localparam logic [8:0] LED_ADDR = 9'o100;

endpackage

// File: rtl/simplez_rr_pick.sv
// Round-robin pick between two requesters with a bounded burst.
// Latency: combinational.
// Backpressure: a requester that is not picked simply keeps its req high.
module simplez_rr_pick
  import simplez_pkg::*;
#(
  parameter int MAXBURST = 4
) (
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last,
  input  logic [3:0] cnt,
  output logic [1:0] gnt     // bit 0 = A, bit 1 = B
);

  localparam logic [3:0] MAXB = 4'(MAXBURST);

  // Lone requester always wins; a tie stays with last until its burst is used up
  always_comb begin
    gnt = 2'b00;
    if (req_a && req_b) begin
      if (cnt < MAXB) gnt = (last == PORT_A) ? 2'b01 : 2'b10;
      else            gnt = (last == PORT_A) ? 2'b10 : 2'b01;
    end else if (req_a) begin
      gnt = 2'b01;
    end else if (req_b) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/simplez_mem_arbiter.sv
// Shares the single-port main memory between the CPU (A) and loader/debug (B).
// Latency: grant and memory pins combinational; read data one cycle after grant.
// Backpressure: an ungranted requester holds req high; bursts are capped at MAXBURST.
module simplez_mem_arbiter
  import simplez_pkg::*;
#(
  parameter int DATAW    = DATAW_DEF,
  parameter int ADDRW    = ADDRW_DEF,
  parameter int MAXBURST = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [ADDRW-1:0] a_addr,
  input  logic [DATAW-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [DATAW-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [ADDRW-1:0] b_addr,
  input  logic [DATAW-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [DATAW-1:0] b_rdata,
  output logic [ADDRW-1:0] mem_addr,
  output logic             mem_wr,
  output logic [DATAW-1:0] mem_wdata,
  input  logic [DATAW-1:0] mem_rdata,
  output logic [1:0]       owner
);

  localparam logic [3:0] MAXB = 4'(MAXBURST);

  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  // Set by reset, cleared by the first grant: last reads as B after reset,
  // yet the first tie must go to A, so the picker sees A while this is set.
  logic       fresh_q, fresh_d;
  logic       a_rvalid_q, a_rvalid_d;
  logic       b_rvalid_q, b_rvalid_d;
  logic [1:0] gnt;
  logic       pick_last;

  assign pick_last = fresh_q ? PORT_A : last_q;

  simplez_rr_pick #(.MAXBURST(MAXBURST)) u_pick (
    .req_a (a_req),
    .req_b (b_req),
    .last  (pick_last),
    .cnt   (cnt_q),
    .gnt   (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  // Drive the memory pins and owner from whichever port holds the grant
  always_comb begin
    mem_addr  = '1;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    owner     = OWN_NONE;
    if (a_gnt) begin
      mem_addr  = a_addr;
      mem_wr    = a_we;
      mem_wdata = a_wdata;
      owner     = OWN_A;
    end else if (b_gnt) begin
      mem_addr  = b_addr;
      mem_wr    = b_we;
      mem_wdata = b_wdata;
      owner     = OWN_B;
    end
  end

  // Burst bookkeeping and read-valid pipeline for the next cycle
  always_comb begin
    last_d     = last_q;
    cnt_d      = cnt_q;
    fresh_d    = fresh_q;
    a_rvalid_d = a_gnt & ~a_we;
    b_rvalid_d = b_gnt & ~b_we;
    if (a_gnt || b_gnt) begin
      fresh_d = 1'b0;
      if (b_gnt == last_q) begin
        cnt_d = (cnt_q >= MAXB) ? MAXB : cnt_q + 4'd1;
      end else begin
        last_d = b_gnt;
        cnt_d  = 4'd1;
      end
    end else begin
      cnt_d = 4'd0;
    end
  end

  // Commit state on the falling edge; synchronous active-low reset
  always_ff @(negedge clk) begin
    if (!rstn) begin
      last_q     <= PORT_B;
      cnt_q      <= 4'd0;
      fresh_q    <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      fresh_q    <= fresh_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? mem_rdata : '0;
  assign b_rdata  = b_rvalid_q ? mem_rdata : '0;

endmodule
